issue_hazard_ctrl: RTL and testbench
====================================

Name: issue_hazard_ctrl

Overview:
- Sits between decode and the ID/EX register; sequences instruction issue from decode into execute.
- Keeps a per-register scoreboard of outstanding destination writes and stalls decode on RAW/WAW hazards using decode's rs1/rs2/rd indices and enables.
- Clears scoreboard entries on writeback. Also provides stall statistics and an error flag.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 never tracked)
- REG_IDX_WIDTH, 5, register index width
- CNT_W, 2, width of each per-register outstanding-write counter
- PERF_W, 32, width of stall-cycle counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- dec_valid_i  in  1  decode holds a valid instruction
- dec_ready_o  out  1  decode may advance (instruction accepted this cycle)
- dec_rs1_idx_i  in  REG_IDX_WIDTH  source 1 index
- dec_rs1_en_i  in  1  rs1 is read
- dec_rs2_idx_i  in  REG_IDX_WIDTH  source 2 index
- dec_rs2_en_i  in  1  rs2 is read
- dec_rd_idx_i  in  REG_IDX_WIDTH  destination index
- dec_rd_en_i  in  1  rd is written
- ex_ready_i  in  1  ID/EX register can accept
- issue_valid_o  out  1  instruction presented to ID/EX this cycle
- flush_i  in  1  kill the instruction in decode (branch/jump redirect)
- wb_valid_i  in  1  writeback retiring a register write
- wb_rd_idx_i  in  REG_IDX_WIDTH  writeback destination
- busy_cnt_o  out  6  number of registers with a nonzero counter
- stall_cycles_o  out  PERF_W  saturating count of hazard stall cycles
- sb_err_o  out  1  sticky: writeback to a register whose counter was 0

Behaviour:
- State and reset:
  - State is the cnt[r] array for r = 1..REG_NUM-1, plus stall_cycles_o and sb_err_o.
  - rst_i asserted (asynchronous): all cnt = 0, stall_cycles_o = 0, sb_err_o = 0.
  - Reset mid-operation discards all outstanding entries.
- Index 0: never tracked. Index-0 sources never cause a hazard; rd = 0 is never recorded; a writeback to 0 is ignored and does not set sb_err_o.
- Hazard conditions (combinational):
  - raw1 = rs1_en & rs1 != 0 & cnt[rs1] != 0; raw2 is the same for rs2.
  - sat = rd_en & rd != 0 & cnt[rd] == 2^CNT_W - 1.
  - hazard = raw1 | raw2 | sat.
  - WAW below saturation is allowed; writebacks are in order.
- Handshake:
  - issue_valid_o = dec_valid_i & ~flush_i & ~hazard.
  - dec_ready_o = (ex_ready_i & ~hazard) | flush_i. A flush always lets decode advance.
  - fire = issue_valid_o & ex_ready_i.
  - Zero-cycle decision; the scoreboard updates on the next rising edge.
- Counter update per edge:
  - If fire & rd_en & rd != 0: cnt[rd] += 1.
  - If wb_valid_i & wb_rd != 0: cnt[wb_rd] -= 1 when nonzero; otherwise cnt stays 0 and sb_err_o is set.
  - Same register incremented and decremented in the same cycle: net unchanged.
- busy_cnt_o: population count of nonzero counters, combinational from registered state.
- stall_cycles_o: increments by 1 each cycle with dec_valid_i & ~flush_i & hazard; saturates at all-ones. A stall caused only by ex_ready_i = 0 is not counted.
- Simultaneous flush and hazard: flush wins. No issue, no stall count, dec_ready_o = 1.
- Issue on the same cycle as a writeback that clears the source register: see Optional Feature.

Optional Feature:
- ISSUE_WB_BYPASS_EN defined:
  - raw1/raw2 are masked when wb_valid_i & wb_rd_idx_i == rs & cnt[rs] == 1, because the register file is write-through.
  - Issue occurs in the writeback cycle.
- Not defined: the source must see cnt == 0 in registered state, so issue occurs one cycle after the writeback.

Test Plan:
- Reset then dec_valid_i = 1, rs1 = 3/en, rd = 5/en, ex_ready_i = 1 -> issue_valid_o = 1 the same cycle; next cycle cnt[5] = 1, busy_cnt_o = 1.
- Issue rd = 5, then an instruction with rs2 = 5/en -> issue_valid_o = 0 and dec_ready_o = 0 until wb_rd = 5. Without the macro, issue happens 1 cycle after the writeback and stall_cycles_o equals the waiting cycles. With ISSUE_WB_BYPASS_EN, issue happens in the writeback cycle.
- Four issues to rd = 7 with no writeback -> 4th stalls on saturation with cnt[7] = 3; one wb to 7 -> 4th issues next cycle.
- Issue rd = 9 and wb_rd = 9 in the same cycle with cnt[9] = 1 -> cnt[9] stays 1. A wb to 4 with cnt[4] = 0 -> sb_err_o = 1 and stays set until reset.
- Hazard on rs1 = 5 with flush_i = 1 -> issue_valid_o = 0, dec_ready_o = 1, stall_cycles_o unchanged. rs1 = 0/en or rd = 0 -> never stalls or records.
- With cnt[5] = 2 and stall_cycles_o = 10, pulse rst_i asynchronously -> all counters, busy_cnt_o, stall_cycles_o and sb_err_o are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/issue_hazard_ctrl.sv
// Issue/hazard controller: per-register outstanding-write scoreboard gating decode -> ID/EX.
// Define ISSUE_WB_BYPASS_EN to let a source issue in the same cycle as its final writeback.
module issue_hazard_ctrl #(
  parameter int REG_NUM       = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int CNT_W         = 2,
  parameter int PERF_W        = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     dec_valid_i,
  output logic                     dec_ready_o,
  input  logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_i,
  input  logic                     dec_rs1_en_i,
  input  logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_i,
  input  logic                     dec_rs2_en_i,
  input  logic [REG_IDX_WIDTH-1:0] dec_rd_idx_i,
  input  logic                     dec_rd_en_i,
  input  logic                     ex_ready_i,
  output logic                     issue_valid_o,
  input  logic                     flush_i,
  input  logic                     wb_valid_i,
  input  logic [REG_IDX_WIDTH-1:0] wb_rd_idx_i,
  output logic [5:0]               busy_cnt_o,
  output logic [PERF_W-1:0]        stall_cycles_o,
  output logic                     sb_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q [REG_NUM];
  logic [CNT_W-1:0]  cnt_d [REG_NUM];
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              err_q, err_d;

  logic raw1, raw2, sat, hazard, fire, wb_err;

  always_comb begin
    raw1 = dec_rs1_en_i && (dec_rs1_idx_i != '0) && (cnt_q[dec_rs1_idx_i] != '0);
    raw2 = dec_rs2_en_i && (dec_rs2_idx_i != '0) && (cnt_q[dec_rs2_idx_i] != '0);
`ifdef ISSUE_WB_BYPASS_EN
    // The register file is write-through, so the last pending write can be consumed as it retires.
    if (wb_valid_i && (wb_rd_idx_i == dec_rs1_idx_i) && (cnt_q[dec_rs1_idx_i] == CNT_ONE))
      raw1 = 1'b0;
    if (wb_valid_i && (wb_rd_idx_i == dec_rs2_idx_i) && (cnt_q[dec_rs2_idx_i] == CNT_ONE))
      raw2 = 1'b0;
`endif
    sat    = dec_rd_en_i && (dec_rd_idx_i != '0) && (cnt_q[dec_rd_idx_i] == CNT_MAX);
    hazard = raw1 || raw2 || sat;
  end

  assign issue_valid_o = dec_valid_i && !flush_i && !hazard;
  assign dec_ready_o   = (ex_ready_i && !hazard) || flush_i;
  assign fire          = issue_valid_o && ex_ready_i;
  assign wb_err        = wb_valid_i && (wb_rd_idx_i != '0) && (cnt_q[wb_rd_idx_i] == '0);

  always_comb begin
    logic inc, dec;
    cnt_d[0] = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      inc = fire && dec_rd_en_i && (dec_rd_idx_i == REG_IDX_WIDTH'(r));
      dec = wb_valid_i && (wb_rd_idx_i == REG_IDX_WIDTH'(r)) && (cnt_q[r] != '0);
      cnt_d[r] = cnt_q[r];
      if (inc && !dec)
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec && !inc)
        cnt_d[r] = cnt_q[r] - CNT_ONE;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (dec_valid_i && !flush_i && hazard && (stall_q != '1))
      stall_d = stall_q + PERF_W'(1);
    err_d = err_q || wb_err;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= cnt_d[r];
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    busy_cnt_o = '0;
    for (int r = 1; r < REG_NUM; r++)
      if (cnt_q[r] != '0) busy_cnt_o = busy_cnt_o + 6'd1;
  end

  assign stall_cycles_o = stall_q;
  assign sb_err_o       = err_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed self-checking bench for issue_hazard_ctrl (timing expectations follow ISSUE_WB_BYPASS_EN).
module tb_issue_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [4:0]  dec_rs1_idx_i, dec_rs2_idx_i, dec_rd_idx_i;
  logic        dec_rs1_en_i, dec_rs2_en_i, dec_rd_en_i;
  logic        ex_ready_i;
  logic        issue_valid_o;
  logic        flush_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_idx_i;
  logic [5:0]  busy_cnt_o;
  logic [31:0] stall_cycles_o;
  logic        sb_err_o;

  int passed = 0;
  int total  = 0;
  int exp_stall = 0;

  issue_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_idx_i(dec_rs1_idx_i), .dec_rs1_en_i(dec_rs1_en_i),
    .dec_rs2_idx_i(dec_rs2_idx_i), .dec_rs2_en_i(dec_rs2_en_i),
    .dec_rd_idx_i(dec_rd_idx_i), .dec_rd_en_i(dec_rd_en_i),
    .ex_ready_i(ex_ready_i), .issue_valid_o(issue_valid_o),
    .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_rd_idx_i(wb_rd_idx_i),
    .busy_cnt_o(busy_cnt_o), .stall_cycles_o(stall_cycles_o), .sb_err_o(sb_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs1, input logic e1,
                     input logic [4:0] rs2, input logic e2,
                     input logic [4:0] rd, input logic ed);
    dec_valid_i   = v;
    dec_rs1_idx_i = rs1; dec_rs1_en_i = e1;
    dec_rs2_idx_i = rs2; dec_rs2_en_i = e2;
    dec_rd_idx_i  = rd;  dec_rd_en_i  = ed;
  endtask

  task automatic dec_idle();
    dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b1;
    wb_valid_i = 1'b0; wb_rd_idx_i = '0;
    dec_idle();
    #3;
    chk("reset_busy", busy_cnt_o, 0);
    chk("reset_stall", stall_cycles_o, 0);
    chk("reset_err", sb_err_o, 0);
    @(negedge clk_i) rst_i = 1'b0;
    tick();

    // basic issue records rd=5
    dec(1, 5'd3, 1, 5'd0, 0, 5'd5, 1); #1;
    $display("txn issue rs1=3 rd=5");
    chk("t1_issue", issue_valid_o, 1);
    chk("t1_ready", dec_ready_o, 1);
    tick(); dec_idle(); #1;
    chk("t1_busy", busy_cnt_o, 1);

    // RAW on rs2=5 until writeback
    dec(1, 5'd0, 0, 5'd5, 1, 5'd0, 0); #1;
    $display("txn raw rs2=5");
    chk("t2_issue_stall", issue_valid_o, 0);
    chk("t2_ready_stall", dec_ready_o, 0);
    tick(); exp_stall++;
    wb_valid_i = 1; wb_rd_idx_i = 5'd5; #1;
`ifdef ISSUE_WB_BYPASS_EN
    chk("t2_issue_wb_cycle", issue_valid_o, 1);
    chk("t2_ready_wb_cycle", dec_ready_o, 1);
    tick(); wb_valid_i = 0;
`else
    chk("t2_issue_wb_cycle", issue_valid_o, 0);
    tick(); exp_stall++; wb_valid_i = 0; #1;
    chk("t2_issue_after_wb", issue_valid_o, 1);
    tick();
`endif
    dec_idle(); #1;
    chk("t2_stall", stall_cycles_o, exp_stall);
    chk("t2_busy", busy_cnt_o, 0);

    // saturation on rd=7
    dec(1, 5'd0, 0, 5'd0, 0, 5'd7, 1); #1;
    $display("txn four writes rd=7");
    chk("t3_issue1", issue_valid_o, 1); tick(); #1;
    chk("t3_issue2", issue_valid_o, 1); tick(); #1;
    chk("t3_issue3", issue_valid_o, 1); tick(); #1;
    chk("t3_sat_issue", issue_valid_o, 0);
    chk("t3_sat_ready", dec_ready_o, 0);
    chk("t3_busy", busy_cnt_o, 1);
    tick(); exp_stall++;
    wb_valid_i = 1; wb_rd_idx_i = 5'd7; #1;
    chk("t3_sat_wb_cycle", issue_valid_o, 0);
    tick(); exp_stall++; wb_valid_i = 0; #1;
    chk("t3_sat_release", issue_valid_o, 1);
    tick(); dec_idle();
    wb_valid_i = 1; wb_rd_idx_i = 5'd7;
    tick(); tick(); tick();
    wb_valid_i = 0; #1;
    chk("t3_drained", busy_cnt_o, 0);
    chk("t3_stall", stall_cycles_o, exp_stall);
    chk("t3_err", sb_err_o, 0);

    // same-cycle inc/dec on rd=9, then erroneous writebacks
    dec(1, 5'd0, 0, 5'd0, 0, 5'd9, 1);
    $display("txn rd=9 inc+wb same cycle");
    tick();
    wb_valid_i = 1; wb_rd_idx_i = 5'd9; #1;
    chk("t4_issue", issue_valid_o, 1);
    tick(); dec_idle(); wb_valid_i = 0; #1;
    chk("t4_busy_net", busy_cnt_o, 1);
    wb_valid_i = 1; wb_rd_idx_i = 5'd9; tick();
    wb_valid_i = 1; wb_rd_idx_i = 5'd0; tick();
    wb_valid_i = 0; #1;
    chk("t4_busy_clear", busy_cnt_o, 0);
    chk("t4_wb0_no_err", sb_err_o, 0);
    $display("txn wb to empty rd=4");
    wb_valid_i = 1; wb_rd_idx_i = 5'd4; tick();
    wb_valid_i = 0; #1;
    chk("t4_err_set", sb_err_o, 1);
    tick(); tick(); #1;
    chk("t4_err_sticky", sb_err_o, 1);

    // back-pressure stall is not counted and does not record
    dec(1, 5'd0, 0, 5'd0, 0, 5'd11, 1); ex_ready_i = 0; #1;
    $display("txn ex_ready low");
    chk("t5_issue", issue_valid_o, 1);
    chk("t5_ready", dec_ready_o, 0);
    tick(); ex_ready_i = 1; dec_idle(); #1;
    chk("t5_busy", busy_cnt_o, 0);
    chk("t5_stall", stall_cycles_o, exp_stall);

    // flush beats hazard; x0 never hazards or records
    dec(1, 5'd0, 0, 5'd0, 0, 5'd5, 1); tick();
    dec(1, 5'd5, 1, 5'd0, 0, 5'd0, 0); flush_i = 1; #1;
    $display("txn flush with hazard");
    chk("t6_flush_issue", issue_valid_o, 0);
    chk("t6_flush_ready", dec_ready_o, 1);
    tick(); flush_i = 0; dec_idle(); #1;
    chk("t6_flush_stall", stall_cycles_o, exp_stall);
    dec(1, 5'd0, 1, 5'd0, 0, 5'd0, 1); #1;
    $display("txn x0 source/dest");
    chk("t6_x0_issue", issue_valid_o, 1);
    tick(); dec_idle(); #1;
    chk("t6_x0_busy", busy_cnt_o, 1);

    // build cnt[5]=2, stall=10, then async reset
    dec(1, 5'd0, 0, 5'd0, 0, 5'd5, 1); tick();
    dec(1, 5'd5, 1, 5'd0, 0, 5'd0, 0);
    while (exp_stall < 10) begin
      tick(); exp_stall++;
    end
    dec_idle(); #1;
    chk("t7_stall10", stall_cycles_o, 10);
    chk("t7_busy", busy_cnt_o, 1);
    chk("t7_err", sb_err_o, 1);
    $display("txn async reset pulse");
    rst_i = 1; #1;
    chk("t7_rst_busy", busy_cnt_o, 0);
    chk("t7_rst_stall", stall_cycles_o, 0);
    chk("t7_rst_err", sb_err_o, 0);
    rst_i = 0;
    tick(); #1;
    chk("t7_post_busy", busy_cnt_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
